// File: rtl/sr_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect from control,
// and the instruction handshake towards decode.
interface sr_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/sr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers returned
// words with their PCs, and flushes/drops stale work on taken branches and jumps.
module sr_fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    sr_fetch_if.master   bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] rspPc;
    logic [PtrW-1:0]   rdPtr;
    logic [PtrW-1:0]   wrPtr;
    logic [CntW-1:0]   count;
    logic [CntW-1:0]   outstanding;
    logic [CntW-1:0]   dropCnt;
    logic [31:0]       dataMem [DEPTH];
    logic [ADDR_W-1:0] pcMem   [DEPTH];

    logic              reqFire;
    logic              pop;
    logic              rspLive;
    logic              push;
    logic [CntW-1:0]   outstandingNext;
    logic [ADDR_W-1:0] target;
    logic [CntW:0]     credit;

    always_comb begin
        reqFire         = bus.imem_req_valid & bus.imem_req_ready;
        pop             = bus.instr_valid & bus.instr_ready;
        // A response with nothing outstanding is a protocol error and is ignored.
        rspLive         = bus.imem_rsp_valid & (outstanding != '0);
        push            = rspLive & (dropCnt == '0) & ~bus.redirect_valid;
        outstandingNext = outstanding + CntW'(reqFire) - CntW'(rspLive);
        target          = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        credit          = {1'b0, outstanding} + {1'b0, count};
    end

    // Registered counts only, so instr_ready never reaches imem_req_valid combinationally.
    assign bus.imem_req_valid = ~rst & (credit < DepthLim);
    assign bus.imem_req_addr  = fetchPc;
    assign bus.instr_valid    = (count != '0);
    assign bus.instr          = dataMem[rdPtr];
    assign bus.instr_pc       = pcMem[rdPtr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dataMem[i] <= '0;
                pcMem[i]   <= '0;
            end
        end else begin
            outstanding <= outstandingNext;
            if (push) begin
                dataMem[wrPtr] <= bus.imem_rsp_data;
                pcMem[wrPtr]   <= rspPc;
            end
            if (bus.redirect_valid) begin
                // Everything still in flight, including a request accepted now, is old-stream.
                fetchPc <= target;
                rspPc   <= target;
                dropCnt <= outstandingNext;
                rdPtr   <= rdPtr + PtrW'(pop);
                wrPtr   <= rdPtr + PtrW'(pop);
                count   <= '0;
            end else begin
                if (reqFire) fetchPc <= fetchPc + ADDR_W'(4);
                if (push) begin
                    rspPc <= rspPc + ADDR_W'(4);
                    wrPtr <= wrPtr + PtrW'(1);
                end
                if (rspLive && (dropCnt != '0)) dropCnt <= dropCnt - CntW'(1);
                rdPtr <= rdPtr + PtrW'(pop);
                count <= count + CntW'(push) - CntW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_sr_fetch_unit.sv
// Randomized bench for sr_fetch_unit: a variable-latency memory plus an epoch-based
// reference model of which PCs must reach decode, in which order.
module tb_sr_fetch_unit;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    sr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } fetchReqT;

    fetchReqT    inflight[$];
    logic [31:0] expQ[$];
    logic [31:0] expReqAddr;
    int          epoch;
    int          cycle;
    int          nChecks;
    int          nPass;

    function automatic logic [31:0] memWord(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic checkEq(string tag, logic [63:0] got, logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    endtask

    task automatic checkOutputs();
        checkEq("instr_valid", 64'(bus.instr_valid), 64'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            checkEq("instr_pc", 64'(bus.instr_pc), 64'(expQ[0]));
            checkEq("instr", 64'(bus.instr), 64'(memWord(expQ[0])));
        end
        checkEq("imem_req_valid", 64'(bus.imem_req_valid),
                64'((inflight.size() + expQ.size()) < int'(DEPTH)));
        if ((inflight.size() + expQ.size()) < int'(DEPTH))
            checkEq("imem_req_addr", 64'(bus.imem_req_addr), 64'(expReqAddr));
    endtask

    // One clock: check state-derived outputs, drive random inputs, advance the model.
    task automatic step(int lat, int pReq, int pPop, int pRedir);
        logic        rspGo, ready, instrReady, redir, mReqValid, mInstrValid, fire, popIt;
        logic [31:0] tgt;
        fetchReqT    r;
        @(negedge clk);
        checkOutputs();
        ready      = ($urandom_range(99) < pReq);
        instrReady = ($urandom_range(99) < pPop);
        redir      = ($urandom_range(99) < pRedir);
        rspGo      = (inflight.size() > 0) && (inflight[0].due <= cycle);
        tgt        = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_FFFF);
        bus.imem_req_ready = ready;
        bus.instr_ready    = instrReady;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        bus.imem_rsp_valid = rspGo;
        bus.imem_rsp_data  = rspGo ? memWord(inflight[0].addr) : $urandom;
        assert (!rspGo || inflight.size() > 0) else $error("response with nothing outstanding");

        mReqValid   = (inflight.size() + expQ.size()) < int'(DEPTH);
        mInstrValid = expQ.size() != 0;
        fire        = mReqValid && ready;
        popIt       = mInstrValid && instrReady;
        if (popIt) void'(expQ.pop_front());
        if (rspGo) begin
            r = inflight.pop_front();
            if (r.epoch == epoch && !redir) expQ.push_back(r.addr);
        end
        if (fire) begin
            r.addr  = expReqAddr;
            r.epoch = epoch;
            r.due   = cycle + lat;
            inflight.push_back(r);
        end
        if (redir) begin
            epoch++;
            expQ.delete();
            expReqAddr = {tgt[31:2], 2'b00};
        end else if (fire) begin
            expReqAddr = expReqAddr + 32'd4;
        end
        cycle++;
    endtask

    task automatic checkResetOutputs(string tag);
        checkEq({tag, " imem_req_valid"}, 64'(bus.imem_req_valid), 64'(0));
        checkEq({tag, " instr_valid"}, 64'(bus.instr_valid), 64'(0));
        checkEq({tag, " instr"}, 64'(bus.instr), 64'(0));
        checkEq({tag, " instr_pc"}, 64'(bus.instr_pc), 64'(0));
        checkEq({tag, " imem_req_addr"}, 64'(bus.imem_req_addr), 64'(RESET_PC));
    endtask

    task automatic clearModel();
        inflight.delete();
        expQ.delete();
        expReqAddr = RESET_PC;
        epoch++;
    endtask

    // Mid-stream async reset, then a stale response arriving while nothing is outstanding.
    task automatic midReset();
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        #2 rst = 1'b1;
        #1 checkResetOutputs("midreset");
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_0BAD;
        @(posedge clk);
        cycle++;
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        cycle   = 0;
        epoch   = 0;
        rst     = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        clearModel();
        #1 checkResetOutputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        repeat (20)  step(1, 100, 100, 0);   // straight-line stream, latency 1
        repeat (12)  step(1, 100, 0, 0);     // decode stalled: buffer fills, requests stop
        repeat (12)  step(1, 100, 100, 0);   // drain and resume
        repeat (300) step(3, 80, 80, 8);     // redirects with responses in flight
        repeat (200) step(2, 70, 60, 45);    // frequent back-to-back redirects
        repeat (150) step(4, 90, 90, 5);
        for (int i = 0; i < 20 && inflight.size() < 2; i++) step(3, 100, 0, 0);
        midReset();
        repeat (150) step(2, 85, 75, 10);
        repeat (100) step(1, 100, 100, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/sr_fetch_unit.md
Name: sr_fetch_unit

Overview:
Instruction fetch stage for the schoolRISCV-style core. It sits directly upstream of the decoder and control unit. It owns the PC and issues in-order requests to the instruction memory over a valid/ready request channel with a variable-latency response channel. It buffers returned words with their PCs and presents them to decode over a valid/ready handshake. It redirects on taken branches and jumps (pcSrcB | pcSrcJ) by flushing the buffer and discarding in-flight responses.

Parameters:
ADDR_W, 32, PC / instruction address width
DEPTH, 4, instruction buffer entries; also the cap on outstanding plus buffered fetches (power of 2, >= 2)
RESET_PC, 0, first fetch address after reset (low 2 bits must be 0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request this cycle
imem_req_addr  out  ADDR_W  fetch address, word aligned
imem_rsp_valid  in  1  response word valid, in request order, no backpressure
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  taken branch/jump from control (pcSrcB | pcSrcJ)
redirect_pc  in  ADDR_W  target address; bits [1:0] ignored and forced to 0
instr_valid  out  1  buffer head valid
instr_ready  in  1  decode consumes head this cycle
instr  out  32  buffer head instruction
instr_pc  out  ADDR_W  PC of buffer head

Behaviour:
- Reset (async, any cycle, including mid-operation): fetch_pc=RESET_PC, rsp_pc=RESET_PC, buffer empty, outstanding=0, drop_cnt=0. Outputs: imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr=0, instr_pc=0.
- Fires: req_fire = imem_req_valid & imem_req_ready; pop = instr_valid & instr_ready.
- imem_req_valid = !rst & (outstanding + count < DEPTH), using registered counts only. No same-cycle credit for pop, so there is no combinational path from instr_ready to imem_req_valid. imem_req_addr = fetch_pc.
- While valid and not accepted, the address is held stable. Exception: a redirect changes the address on the next cycle.
- On req_fire without redirect: fetch_pc += 4, wrapping modulo 2^ADDR_W.
- Outstanding counter: +req_fire, -imem_rsp_valid. It counts both live and to-be-dropped requests.
- Response when drop_cnt > 0: discarded, drop_cnt -= 1.
- Response when drop_cnt = 0 and no redirect this cycle: write {rsp_pc, data} to the buffer tail, rsp_pc += 4. Overflow is impossible by construction.
- Response with outstanding = 0: protocol error, ignored; the bench flags it with an assertion.
- Buffer: DEPTH-entry FIFO with registered storage. instr, instr_pc and instr_valid come from the head, with no response-to-output bypass.
- Latency: request accepted in cycle r, response in r+L, instr_valid in r+L+1.
- Throughput: sustains 1 instruction per cycle for L <= DEPTH-2.
- Redirect cycle (redirect_valid=1):
  - A pop in the same cycle completes; the head is the branch/jump itself.
  - All other buffer entries are flushed; count=0 next cycle.
  - A same-cycle response is discarded regardless of drop_cnt.
  - drop_cnt_next = outstanding + req_fire - imem_rsp_valid. Any request accepted this cycle is old-stream.
  - fetch_pc = rsp_pc = {redirect_pc[ADDR_W-1:2], 2'b00}. The next imem_req_addr is the target at cycle t+1.
- Back-to-back redirects: the latest redirect wins, and drop_cnt is recomputed each time.
- A pop when empty is a no-op.
- Simultaneous push and pop keep count unchanged; full plus pop plus push is legal.

Test Plan:
1. Reset release, memory latency 1, instr_ready=1, words 0x00000013 (nop) at 0x0,0x4,0x8 → req addrs 0,4,8 on cycles 0,1,2; instr_valid from cycle 2; instr_pc 0,4,8 in consecutive cycles.
2. instr_ready=0 for 10 cycles, latency 1 → exactly 4 requests issued, then imem_req_valid=0; buffer holds PCs 0..0xC; releasing ready drains in order and fetching resumes.
3. Latency 3 with 2 requests in flight, redirect_valid=1 with redirect_pc=0x103 while head (PC 0x8) pops → next req addr 0x100; both stale responses dropped; next instr_pc=0x100.
4. Redirect in the same cycle as imem_rsp_valid and req_fire → response discarded, drop_cnt counts the new old-stream request, no stale PC ever reaches instr_pc.
5. Two redirects on consecutive cycles (0x40 then 0x80) → only PCs 0x80, 0x84… are delivered.
6. Assert rst mid-stream with outstanding=2 → outputs reset immediately; after release fetch restarts at RESET_PC and late stale responses are ignored (outstanding=0).
